sram_axi_bridge: RTL



---
 rtl/sram_axi_bridge_if.sv | 69 ++++++
 rtl/sram_axi_bridge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-side bus between the SRAM-to-AXI bridge and the downstream slave.
interface sram_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst and data SRAM-like ports onto one AXI3 master.
// One read and one write may be outstanding; the data port is limited to a
// single transaction so its completions come back in request order.
//
// state  | meaning
// R_IDLE | no read in flight, arbitrating data vs inst reads
// R_AR   | AR issued, waiting for arready
// R_R    | waiting for the single read beat
// W_IDLE | no write in flight
// W_SEND | AW and W issued, each retired on its own handshake
// W_B    | waiting for the write response
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  sram_axi_bridge_if.master axi
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_B} wstate_e;

  rstate_e rstate_q, rstate_d;
  wstate_e wstate_q, wstate_d;

  logic        data_busy_q, data_busy_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic data_rd_acc, inst_rd_acc, data_wr_acc;
  logic r_done, b_done;

  // Inputs that carry no meaning for this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                           axi.rresp, axi.rlast, axi.bid, axi.bresp};

  // Request arbitration: data read beats inst read; data is single-outstanding.
  always_comb begin
    data_rd_acc = (rstate_q == R_IDLE) && (wstate_q == W_IDLE) && data_sram_req
                  && !data_sram_wr && !data_busy_q;
    inst_rd_acc = (rstate_q == R_IDLE) && inst_sram_req && !data_rd_acc;
    data_wr_acc = (wstate_q == W_IDLE) && data_sram_req && data_sram_wr && !data_busy_q;
    r_done      = (rstate_q == R_R) && axi.rvalid;
    b_done      = (wstate_q == W_B) && axi.bvalid;
  end

  // FSM state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate_q <= R_IDLE;
      wstate_q <= W_IDLE;
    end else begin
      rstate_q <= rstate_d;
      wstate_q <= wstate_d;
    end
  end

  // Read FSM next state.
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (data_rd_acc || inst_rd_acc) rstate_d = R_AR;
      R_AR:    if (axi.arready) rstate_d = R_R;
      R_R:     if (axi.rvalid) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write FSM next state; W_SEND leaves once both AW and W have handshaken.
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (data_wr_acc) wstate_d = W_SEND;
      W_SEND:  if (aw_done_d && w_done_d) wstate_d = W_B;
      W_B:     if (axi.bvalid) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Outputs: handshake strobes are decoded from state, payloads from latches.
  always_comb begin
    inst_sram_addr_ok = inst_rd_acc;
    data_sram_addr_ok = data_rd_acc || data_wr_acc;
    inst_sram_data_ok = r_done && (axi.rid != DATA_ID);
    data_sram_data_ok = (r_done && (axi.rid == DATA_ID)) || b_done;
    inst_sram_rdata   = axi.rdata;
    data_sram_rdata   = axi.rdata;

    axi.arid    = arid_q;
    axi.araddr  = araddr_q;
    axi.arsize  = arsize_q;
    axi.arlen   = 8'd0;
    axi.arburst = 2'd1;
    axi.arlock  = 2'd0;
    axi.arcache = 4'd0;
    axi.arprot  = 3'd0;
    axi.arvalid = (rstate_q == R_AR);
    axi.rready  = (rstate_q == R_R);

    axi.awid    = DATA_ID;
    axi.awaddr  = awaddr_q;
    axi.awsize  = awsize_q;
    axi.awlen   = 8'd0;
    axi.awburst = 2'd1;
    axi.awlock  = 2'd0;
    axi.awcache = 4'd0;
    axi.awprot  = 3'd0;
    axi.awvalid = (wstate_q == W_SEND) && !aw_done_q;

    axi.wid     = DATA_ID;
    axi.wdata   = wdata_q;
    axi.wstrb   = wstrb_q;
    axi.wlast   = 1'b1;
    axi.wvalid  = (wstate_q == W_SEND) && !w_done_q;
    axi.bready  = (wstate_q == W_B);
  end

  // Datapath next values: latch request fields on acceptance, track write halves.
  always_comb begin
    araddr_d    = araddr_q;
    arsize_d    = arsize_q;
    arid_d      = arid_q;
    awaddr_d    = awaddr_q;
    awsize_d    = awsize_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    data_busy_d = data_busy_q;

    if (data_rd_acc) begin
      araddr_d = data_sram_addr;
      arsize_d = {1'b0, data_sram_size};
      arid_d   = DATA_ID;
    end else if (inst_rd_acc) begin
      araddr_d = inst_sram_addr;
      arsize_d = {1'b0, inst_sram_size};
      arid_d   = INST_ID;
    end

    if (data_wr_acc) begin
      awaddr_d = data_sram_addr;
      awsize_d = {1'b0, data_sram_size};
      wdata_d  = data_sram_wdata;
      wstrb_d  = data_sram_wstrb;
    end

    // Acceptance requires !data_busy_q, so set and clear never collide.
    if (data_rd_acc || data_wr_acc) data_busy_d = 1'b1;
    else if (data_sram_data_ok)     data_busy_d = 1'b0;

    aw_done_d = (wstate_q == W_SEND) && (aw_done_q || axi.awready);
    w_done_d  = (wstate_q == W_SEND) && (w_done_q || axi.wready);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      araddr_q    <= 32'd0;
      arsize_q    <= 3'd0;
      arid_q      <= 4'd0;
      awaddr_q    <= 32'd0;
      awsize_q    <= 3'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      data_busy_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      araddr_q    <= araddr_d;
      arsize_q    <= arsize_d;
      arid_q      <= arid_d;
      awaddr_q    <= awaddr_d;
      awsize_q    <= awsize_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      data_busy_q <= data_busy_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

endmodule
